// File: rtl/nyquist_sampler_if.sv
// ---------------------------------------------------------------------------
// nyquist_sampler_if
// Purpose: bundles the conversion handshake towards the ADC driver and the
//          load handshake towards the DAC driver into one interface.
// Signals:
//   convReq   one-cycle conversion request (sampler -> ADC driver)
//   adcValid  one-cycle pulse, adcVa/adcVb hold a new frame (ADC -> sampler)
//   adcVa/Vb  two's complement samples, ADC_WIDTH bits each
//   dacStart  one-cycle start pulse (sampler -> DAC driver)
//   dacBusy   DAC transfer in progress (DAC driver -> sampler)
//   dacVa/Vb  offset-binary codes, DAC_WIDTH bits each, held between updates
// Modports: master = sampler side, slave = ADC/DAC driver side.
// ---------------------------------------------------------------------------
interface nyquist_sampler_if #(
  parameter int ADC_WIDTH = 14,
  parameter int DAC_WIDTH = 12
);
  logic                 convReq;
  logic                 adcValid;
  logic [ADC_WIDTH-1:0] adcVa;
  logic [ADC_WIDTH-1:0] adcVb;
  logic                 dacStart;
  logic                 dacBusy;
  logic [DAC_WIDTH-1:0] dacVa;
  logic [DAC_WIDTH-1:0] dacVb;

  modport master (
    output convReq, dacStart, dacVa, dacVb,
    input  adcValid, adcVa, adcVb, dacBusy
  );

  modport slave (
    input  convReq, dacStart, dacVa, dacVb,
    output adcValid, adcVa, adcVb, dacBusy
  );
endinterface

// File: rtl/nyquist_sampler.sv
// ---------------------------------------------------------------------------
// nyquist_sampler
// Purpose: sample-rate engine between the ADC and DAC drivers. Generates the
//          SPI serial clock, issues conversion requests at a programmable
//          period, converts both channels from two's complement to DAC
//          offset binary and hands them to the DAC with a start pulse.
// Ports:
//   clk50m_i     50 MHz system clock
//   rst_i        synchronous active-high reset
//   sckDiv_i     SPI_SCK half-period in clock cycles (0 behaves as 1)
//   rate_i       sample period in clock cycles (clamped up to MIN_RATE)
//   enable_i     run sampling; low clears the rate counter
//   bus          nyquist_sampler_if.master (ADC/DAC handshakes and data)
//   spiSck_o     divided serial clock
//   sampleCnt_o  frames delivered to the DAC, wraps at 16 bits
//   overrun_o    sticky: a sample tick arrived while busy with a frame
//   timeout_o    sticky: the ADC never answered a conversion request
// Build option: define NYQUIST_ROUNDING_EN for round-half-up conversion with
//               saturation; this spends one extra cycle in LOAD.
// ---------------------------------------------------------------------------
module nyquist_sampler #(
  parameter int ADC_WIDTH    = 14,
  parameter int DAC_WIDTH    = 12,
  parameter int DIV_WIDTH    = 8,
  parameter int RATE_WIDTH   = 16,
  parameter int MIN_RATE     = 64,
  parameter int CONV_TIMEOUT = 1024
) (
  input  logic                  clk50m_i,
  input  logic                  rst_i,
  input  logic [DIV_WIDTH-1:0]  sckDiv_i,
  input  logic [RATE_WIDTH-1:0] rate_i,
  input  logic                  enable_i,
  nyquist_sampler_if.master     bus,
  output logic                  spiSck_o,
  output logic [15:0]           sampleCnt_o,
  output logic                  overrun_o,
  output logic                  timeout_o
);

  localparam int TO_W = $clog2(CONV_TIMEOUT + 1);
  localparam logic [DAC_WIDTH-1:0] MIDSCALE = {1'b1, {(DAC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CONVERT, LOAD, DAC_WAIT} state_t;

  // SCK divider: the divisor is captured only on a wrap so a change never
  // produces a runt half-period.
  logic [DIV_WIDTH-1:0] sckCnt_q, sckCnt_d;
  logic [DIV_WIDTH-1:0] sckDivLat_q, sckDivLat_d;
  logic [DIV_WIDTH-1:0] sckDivEff;
  logic                 spiSck_q, spiSck_d;

  assign sckDivEff = (sckDiv_i == '0) ? DIV_WIDTH'(1) : sckDiv_i;

  always_comb begin
    sckCnt_d    = sckCnt_q + DIV_WIDTH'(1);
    sckDivLat_d = sckDivLat_q;
    spiSck_d    = spiSck_q;
    if (sckCnt_q == sckDivLat_q - DIV_WIDTH'(1)) begin
      sckCnt_d    = '0;
      sckDivLat_d = sckDivEff;
      spiSck_d    = ~spiSck_q;
    end
  end

  always_ff @(posedge clk50m_i) begin
    if (rst_i) begin
      sckCnt_q    <= '0;
      sckDivLat_q <= sckDivEff;
      spiSck_q    <= 1'b0;
    end else begin
      sckCnt_q    <= sckCnt_d;
      sckDivLat_q <= sckDivLat_d;
      spiSck_q    <= spiSck_d;
    end
  end

  // Rate counter: the clamped period is reloaded at every wrap and
  // continuously while disabled, so enabling starts a fresh full period.
  logic [RATE_WIDTH-1:0] rateCnt_q, rateCnt_d;
  logic [RATE_WIDTH-1:0] rateLat_q, rateLat_d;
  logic [RATE_WIDTH-1:0] rateEff;
  logic                  tick;

  assign rateEff = (rate_i < RATE_WIDTH'(MIN_RATE)) ? RATE_WIDTH'(MIN_RATE) : rate_i;
  assign tick    = enable_i && (rateCnt_q == rateLat_q - RATE_WIDTH'(1));

  always_comb begin
    rateCnt_d = rateCnt_q + RATE_WIDTH'(1);
    rateLat_d = rateLat_q;
    if (!enable_i || tick) begin
      rateCnt_d = '0;
      rateLat_d = rateEff;
    end
  end

  always_ff @(posedge clk50m_i) begin
    if (rst_i) begin
      rateCnt_q <= '0;
      rateLat_q <= rateEff;
    end else begin
      rateCnt_q <= rateCnt_d;
      rateLat_q <= rateLat_d;
    end
  end

  // Code conversion. Flipping the sign bit maps two's complement onto
  // offset binary; the top DAC_WIDTH bits of that are the DAC code.
  logic [ADC_WIDTH-1:0] latchA_q, latchB_q;
  logic [DAC_WIDTH-1:0] loadA, loadB;
  logic                 loadReady;

`ifdef NYQUIST_ROUNDING_EN
  localparam logic [ADC_WIDTH:0] HALF_LSB = (ADC_WIDTH+1)'(1) << (ADC_WIDTH - DAC_WIDTH - 1);

  // The extra top bit of the sum catches overflow past positive full scale.
  function automatic logic [DAC_WIDTH-1:0] roundCode(input logic [ADC_WIDTH-1:0] s);
    logic [ADC_WIDTH:0] sum;
    sum = {1'b0, ~s[ADC_WIDTH-1], s[ADC_WIDTH-2:0]} + HALF_LSB;
    return sum[ADC_WIDTH] ? {DAC_WIDTH{1'b1}} : sum[ADC_WIDTH-1 -: DAC_WIDTH];
  endfunction

  logic                 roundDone_q;
  logic [DAC_WIDTH-1:0] roundA_q, roundB_q;

  assign loadReady = roundDone_q;
  assign loadA     = roundA_q;
  assign loadB     = roundB_q;
`else
  function automatic logic [DAC_WIDTH-1:0] truncCode(input logic [ADC_WIDTH-1:0] s);
    return {~s[ADC_WIDTH-1], s[ADC_WIDTH-2 -: DAC_WIDTH-1]};
  endfunction

  assign loadReady = 1'b1;
  assign loadA     = truncCode(latchA_q);
  assign loadB     = truncCode(latchB_q);
`endif

  // Frame sequencer. All handshake outputs are registered here; a tick
  // that finds the FSM away from IDLE is dropped and flagged as overrun.
  state_t               state_q;
  logic [TO_W-1:0]      toCnt_q;
  logic                 waitFirst_q;
  logic                 convReq_q, dacStart_q, overrun_q, timeout_q;
  logic [DAC_WIDTH-1:0] dacVa_q, dacVb_q;
  logic [15:0]          sampleCnt_q;

  always_ff @(posedge clk50m_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      toCnt_q     <= '0;
      waitFirst_q <= 1'b0;
      convReq_q   <= 1'b0;
      dacStart_q  <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
      dacVa_q     <= MIDSCALE;
      dacVb_q     <= MIDSCALE;
      sampleCnt_q <= '0;
      latchA_q    <= '0;
      latchB_q    <= '0;
`ifdef NYQUIST_ROUNDING_EN
      roundDone_q <= 1'b0;
      roundA_q    <= MIDSCALE;
      roundB_q    <= MIDSCALE;
`endif
    end else begin
      convReq_q  <= 1'b0;
      dacStart_q <= 1'b0;
      if (tick && state_q != IDLE) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (tick) begin
            convReq_q <= 1'b1;
            toCnt_q   <= '0;
            state_q   <= CONVERT;
          end
        end
        CONVERT: begin
          if (bus.adcValid) begin
            latchA_q <= bus.adcVa;
            latchB_q <= bus.adcVb;
            state_q  <= LOAD;
          end else if (toCnt_q == TO_W'(CONV_TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            toCnt_q <= toCnt_q + TO_W'(1);
          end
        end
        LOAD: begin
`ifdef NYQUIST_ROUNDING_EN
          if (!roundDone_q) begin
            roundA_q    <= roundCode(latchA_q);
            roundB_q    <= roundCode(latchB_q);
            roundDone_q <= 1'b1;
          end
`endif
          if (loadReady) begin
            dacVa_q <= loadA;
            dacVb_q <= loadB;
            if (!bus.dacBusy) begin
              dacStart_q  <= 1'b1;
              sampleCnt_q <= sampleCnt_q + 16'd1;
              waitFirst_q <= 1'b1;
              state_q     <= DAC_WAIT;
`ifdef NYQUIST_ROUNDING_EN
              roundDone_q <= 1'b0;
`endif
            end
          end
        end
        DAC_WAIT: begin
          // First cycle gives the DAC driver time to raise busy.
          if (waitFirst_q) waitFirst_q <= 1'b0;
          else if (!bus.dacBusy) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.convReq  = convReq_q;
  assign bus.dacStart = dacStart_q;
  assign bus.dacVa    = dacVa_q;
  assign bus.dacVb    = dacVb_q;
  assign spiSck_o     = spiSck_q;
  assign sampleCnt_o  = sampleCnt_q;
  assign overrun_o    = overrun_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_nyquist_sampler.sv
// ---------------------------------------------------------------------------
// tb_nyquist_sampler
// Purpose: self-checking bench for nyquist_sampler. An ADC model answers
//          conversion requests after a programmable latency and pushes the
//          expected DAC codes into a scoreboard; a DAC model pops them on
//          every start pulse and compares codes, latency and frame count.
// Build option: NYQUIST_ROUNDING_EN selects the rounding reference model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_nyquist_sampler;

`ifdef NYQUIST_ROUNDING_EN
  localparam int LOAD_CYCLES = 2;
  localparam logic [11:0] EXP_SMALL = 12'h801;
`else
  localparam int LOAD_CYCLES = 1;
  localparam logic [11:0] EXP_SMALL = 12'h800;
`endif

  logic        clk;
  logic        rst;
  logic [7:0]  sckDiv;
  logic [15:0] rate;
  logic        enable;
  logic        spiSck;
  logic [15:0] sampleCnt;
  logic        overrun;
  logic        timeout;

  nyquist_sampler_if #(.ADC_WIDTH(14), .DAC_WIDTH(12)) bus ();

  nyquist_sampler #(
    .ADC_WIDTH(14), .DAC_WIDTH(12), .DIV_WIDTH(8), .RATE_WIDTH(16),
    .MIN_RATE(64), .CONV_TIMEOUT(1024)
  ) dut (
    .clk50m_i(clk), .rst_i(rst), .sckDiv_i(sckDiv), .rate_i(rate),
    .enable_i(enable), .bus(bus), .spiSck_o(spiSck),
    .sampleCnt_o(sampleCnt), .overrun_o(overrun), .timeout_o(timeout)
  );

  // 50 MHz clock and a free-running cycle counter for timing checks.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checkCount = 0;
  int failCount  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference conversion written in integer arithmetic.
  function automatic logic [11:0] expCode(input logic [13:0] s);
    int u;
    u = $signed(s) + 8192;
`ifdef NYQUIST_ROUNDING_EN
    u = u + 2;
    if (u > 16383) u = 16383;
`endif
    return 12'(u / 4);
  endfunction

  // Shared stimulus/model state.
  logic [23:0] expQ[$];
  logic [13:0] patA[$], patB[$];
  logic [13:0] adcValA = 14'h0, adcValB = 14'h0;
  int  adcLatency = 40;
  bit  adcRespond = 1'b1;
  bit  adcRandom  = 1'b0;
  int  pending = 0, reqCount = 0, lastReqCyc = 0, prevReqCyc = 0, reqLatency = 0;
  int  startCount = 0, lastStartCyc = 0, prevStartCyc = 0, expFrames = 0;
  int  busyLen = 0, busyCnt = 0;
  bit  forceBusy = 1'b0;

  // ADC model: answers each conversion request after adcLatency cycles and
  // records the code the DAC should eventually receive.
  initial begin
    logic [13:0] a, b;
    bus.adcValid = 1'b0;
    bus.adcVa    = '0;
    bus.adcVb    = '0;
    forever begin
      @(negedge clk);
      bus.adcValid = 1'b0;
      if (rst) pending = 0;
      if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          if (patA.size() > 0) begin
            a = patA.pop_front();
            b = patB.pop_front();
          end else if (adcRandom) begin
            a = 14'($urandom);
            b = 14'($urandom);
          end else begin
            a = adcValA;
            b = adcValB;
          end
          bus.adcVa    = a;
          bus.adcVb    = b;
          bus.adcValid = 1'b1;
          expQ.push_back({expCode(a), expCode(b)});
        end
      end
      if (bus.convReq) begin
        reqCount++;
        prevReqCyc = lastReqCyc;
        lastReqCyc = cyc;
        if (adcRespond) begin
          reqLatency = adcRandom ? int'($urandom_range(5, 30)) : adcLatency;
          pending    = reqLatency;
        end
      end
    end
  end

  // DAC model and scoreboard: every start pulse pops one expected frame.
  initial begin
    logic [23:0] exp;
    bus.dacBusy = 1'b0;
    forever begin
      @(negedge clk);
      if (busyCnt > 0) busyCnt--;
      if (bus.dacStart) begin
        startCount++;
        prevStartCyc = lastStartCyc;
        lastStartCyc = cyc;
        if (expQ.size() == 0) begin
          checkOutput("startWithoutFrame", 1, 0);
        end else begin
          exp = expQ.pop_front();
          checkOutput("dacVa", 32'(bus.dacVa), 32'(exp[23:12]));
          checkOutput("dacVb", 32'(bus.dacVb), 32'(exp[11:0]));
        end
        checkOutput("reqToStart", cyc - lastReqCyc, reqLatency + 1 + LOAD_CYCLES);
        expFrames++;
        checkOutput("sampleCnt", 32'(sampleCnt), expFrames);
        busyCnt = busyLen;
      end
      bus.dacBusy = forceBusy || (busyCnt > 0);
    end
  end

  task automatic applyStimulus(input bit r, input logic [7:0] div,
                               input logic [15:0] rt, input bit en);
    rst    = r;
    sckDiv = div;
    rate   = rt;
    enable = en;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic measureSckPeriod(output int period);
    int  edges = 0;
    int  first = 0;
    logic prev;
    period = -1;
    prev   = spiSck;
    for (int i = 0; i < 200 && edges < 2; i++) begin
      @(negedge clk);
      if (spiSck && !prev) begin
        edges++;
        if (edges == 1) first = cyc;
        else period = cyc - first;
      end
      prev = spiSck;
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_dacVa"}, 32'(bus.dacVa), 32'h800);
    checkOutput({tag, "_dacVb"}, 32'(bus.dacVb), 32'h800);
    checkOutput({tag, "_sampleCnt"}, 32'(sampleCnt), 0);
    checkOutput({tag, "_overrun"}, 32'(overrun), 0);
    checkOutput({tag, "_timeout"}, 32'(timeout), 0);
    checkOutput({tag, "_convReq"}, 32'(bus.convReq), 0);
    checkOutput({tag, "_dacStart"}, 32'(bus.dacStart), 0);
    checkOutput({tag, "_spiSck"}, 32'(spiSck), 0);
  endtask

  // Main sequence.
  initial begin
    int period, r0, s0, reqCyc;
    applyStimulus(1'b1, 8'd4, 16'd200, 1'b0);
    waitCycles(3);
    checkResetState("reset");

    // SCK divider with sampling disabled.
    applyStimulus(1'b0, 8'd4, 16'd200, 1'b0);
    waitCycles(10);
    measureSckPeriod(period);
    checkOutput("sckPeriodDiv4", period, 8);
    sckDiv = 8'd0;
    waitCycles(10);
    measureSckPeriod(period);
    checkOutput("sckPeriodDiv0", period, 2);
    checkOutput("noReqWhileDisabled", reqCount, 0);

    // Full-scale frames at RATE=200.
    adcLatency = 40;
    adcValA    = 14'h1FFF;
    adcValB    = 14'h2000;
    enable     = 1'b1;
    for (int i = 0; i < 1000 && startCount < 3; i++) @(negedge clk);
    checkOutput("frames200", startCount, 3);
    checkOutput("reqSpacing200", lastReqCyc - prevReqCyc, 200);
    checkOutput("startSpacing200", lastStartCyc - prevStartCyc, 200);
    checkOutput("fullScaleVa", 32'(bus.dacVa), 32'hFFF);
    checkOutput("fullScaleVb", 32'(bus.dacVb), 32'h000);
    checkOutput("sampleCnt200", 32'(sampleCnt), 3);

    // RATE below the minimum is clamped.
    rate = 16'd10;
    r0   = reqCount;
    for (int i = 0; i < 600 && reqCount < r0 + 3; i++) @(negedge clk);
    checkOutput("reqsClamped", reqCount - r0, 3);
    checkOutput("reqSpacingClamped", lastReqCyc - prevReqCyc, 64);
    checkOutput("noOverrunYet", 32'(overrun), 0);

    // Slow ADC: every second tick is dropped.
    adcLatency = 100;
    rate       = 16'd64;
    s0         = startCount;
    for (int i = 0; i < 800 && startCount < s0 + 3; i++) @(negedge clk);
    checkOutput("framesSlowAdc", startCount - s0, 3);
    checkOutput("startSpacingSlow", lastStartCyc - prevStartCyc, 128);
    checkOutput("reqSpacingSlow", lastReqCyc - prevReqCyc, 128);
    checkOutput("overrunSet", 32'(overrun), 1);

    // ADC never answers: conversion timeout.
    enable = 1'b0;
    waitCycles(300);
    adcRespond = 1'b0;
    rate       = 16'd2000;
    enable     = 1'b1;
    r0         = reqCount;
    s0         = startCount;
    for (int i = 0; i < 2100 && reqCount == r0; i++) @(negedge clk);
    checkOutput("timeoutReqSeen", reqCount - r0, 1);
    reqCyc = lastReqCyc;
    checkOutput("timeoutNotEarly", 32'(timeout), 0);
    for (int i = 0; i < 1100 && !timeout; i++) @(negedge clk);
    checkOutput("timeoutDelay", cyc - reqCyc, 1024);
    checkOutput("timeoutFsmIdle", 32'(dut.state_q), 0);
    for (int i = 0; i < 1100 && reqCount < r0 + 2; i++) @(negedge clk);
    checkOutput("reqAfterTimeout", reqCount - r0, 2);
    checkOutput("reqSpacingTimeout", lastReqCyc - prevReqCyc, 2000);
    checkOutput("noStartOnTimeout", startCount - s0, 0);

    // DAC stays busy in LOAD, then reset mid-frame.
    applyStimulus(1'b1, 8'd0, 16'd100, 1'b0);
    waitCycles(2);
    expQ.delete();
    expFrames  = 0;
    adcRespond = 1'b1;
    adcLatency = 10;
    adcValA    = 14'h0123;
    adcValB    = 14'h3ABC;
    forceBusy  = 1'b1;
    applyStimulus(1'b0, 8'd0, 16'd100, 1'b1);
    r0 = reqCount;
    s0 = startCount;
    for (int i = 0; i < 200 && reqCount == r0; i++) @(negedge clk);
    checkOutput("busyReqSeen", reqCount - r0, 1);
    waitCycles(300);
    checkOutput("busyNoStart", startCount - s0, 0);
    checkOutput("busyLoadVa", 32'(bus.dacVa), 32'(expCode(14'h0123)));
    checkOutput("busyLoadVb", 32'(bus.dacVb), 32'(expCode(14'h3ABC)));
    checkOutput("busyOverrun", 32'(overrun), 1);
    rst = 1'b1;
    waitCycles(1);
    checkResetState("midReset");
    applyStimulus(1'b0, 8'd0, 16'd100, 1'b0);
    forceBusy = 1'b0;
    expQ.delete();
    expFrames = 0;
    waitCycles(30);
    checkOutput("noStartAfterReset", startCount - s0, 0);

    // Boundary and random samples with a busy DAC model.
    patA = '{14'h0002, 14'h1FFF, 14'h2000, 14'h0000};
    patB = '{14'h3FFE, 14'h0001, 14'h1FFE, 14'h2001};
    adcRandom = 1'b1;
    busyLen   = 15;
    s0        = startCount;
    applyStimulus(1'b0, 8'd3, 16'd80, 1'b1);
    for (int i = 0; i < 200 && startCount < s0 + 1; i++) @(negedge clk);
    checkOutput("smallPositiveVa", 32'(bus.dacVa), 32'(EXP_SMALL));
    for (int i = 0; i < 200 && startCount < s0 + 2; i++) @(negedge clk);
    checkOutput("saturatedVa", 32'(bus.dacVa), 32'hFFF);
    for (int i = 0; i < 1200 && startCount < s0 + 10; i++) @(negedge clk);
    checkOutput("randomFrames", startCount - s0, 10);
    enable = 1'b0;
    waitCycles(200);
    checkOutput("scoreboardEmpty", expQ.size(), 0);
    checkOutput("finalSampleCnt", 32'(sampleCnt), expFrames);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
